lfsr_err_injector: RTL and testbench

Stimulus stage that drives the valid strobe and the corruption flag of the LFSR generator/checker pair. It produces a programmable-rate word strobe (`o_valid`) and marks selected strobed words as corrupted (`o_corrupt`): single bursts on trigger, periodic bursts, or continuous. Its outputs replace the raw VIO drives, so lock/unlock behaviour can be exercised repeatably in hardware. Placement: upstream of `lfsr_gen`/`lfsr_checker`, with VIO driving its control inputs.

---
 rtl/lfsr_err_injector.sv | 169 ++++++++++++++++
 tb/tb_lfsr_err_injector.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_err_injector.sv
// Valid-strobe and corruption-flag generator for the LFSR generator/checker pair.
// Define ERR_INJ_BURST_CNT_EN to build the saturating completed-burst counter; otherwise o_burst_cnt reads 0.
module lfsr_err_injector #(
    parameter int PERIOD_W = 16,
    parameter int BURST_W  = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_enable,
    input  logic [7:0]          i_valid_div,
    input  logic [1:0]          i_mode,
    input  logic                i_trigger,
    input  logic [PERIOD_W-1:0] i_period,
    input  logic [BURST_W-1:0]  i_burst_len,
    output logic                o_valid,
    output logic                o_corrupt,
    output logic                o_busy,
    output logic [15:0]         o_burst_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

    localparam logic [1:0] M_OFF      = 2'b00;
    localparam logic [1:0] M_SINGLE   = 2'b01;
    localparam logic [1:0] M_PERIODIC = 2'b10;
    localparam logic [1:0] M_CONT     = 2'b11;
    localparam int CMP_W = ((PERIOD_W > BURST_W) ? PERIOD_W : BURST_W) + 1;

    state_t               state_q, state_d;
    logic [7:0]           dcnt_q, dcnt_d;
    logic                 trig_q, trig_prev_q;
    logic [BURST_W-1:0]   rem_q, rem_d;
    logic [PERIOD_W-1:0]  pcnt_q, pcnt_d;
    logic                 per_run_q, per_run_d;
    logic                 valid_q, corrupt_q, corrupt_d, busy_q;

    logic                 tick, trig_rise, abort, reload_ok, long_period, gap_done;
    logic [1:0]           run_mode;
    logic [CMP_W-1:0]     period_ext, blen_ext, pnext_ext;

    // A stale divider count above a freshly lowered i_valid_div still ticks instead of wrapping.
    assign tick      = i_enable && (dcnt_q >= i_valid_div);
    assign dcnt_d    = !i_enable ? 8'd0 : (tick ? 8'd0 : dcnt_q + 8'd1);
    assign trig_rise = trig_q && !trig_prev_q;

    // A busy FSM is aborted when disabled or when the mode no longer matches the one that started it.
    assign run_mode  = per_run_q ? M_PERIODIC : M_SINGLE;
    assign abort     = (state_q != S_IDLE) && (!i_enable || (i_mode != run_mode));
    assign reload_ok = (i_burst_len != '0);

    assign period_ext  = CMP_W'(i_period);
    assign blen_ext    = CMP_W'(i_burst_len);
    assign pnext_ext   = CMP_W'(pcnt_q) + CMP_W'(1);
    assign long_period = (period_ext > blen_ext);
    assign gap_done    = (pnext_ext >= period_ext);

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        pcnt_d    = pcnt_q;
        per_run_d = per_run_q;
        corrupt_d = 1'b0;
        if (i_mode == M_CONT) begin
            state_d   = S_IDLE;
            corrupt_d = tick;
        end else if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (reload_ok && i_enable &&
                        (((i_mode == M_SINGLE) && trig_rise) || (i_mode == M_PERIODIC))) begin
                        state_d   = S_BURST;
                        rem_d     = i_burst_len;
                        pcnt_d    = '0;
                        per_run_d = (i_mode == M_PERIODIC);
                    end
                end
                S_BURST: begin
                    if (tick) begin
                        corrupt_d = 1'b1;
                        rem_d     = rem_q - BURST_W'(1);
                        pcnt_d    = pcnt_q + PERIOD_W'(1);
                        if (rem_q <= BURST_W'(1)) begin
                            if (!per_run_q) begin
                                state_d = S_IDLE;
                            end else if (long_period) begin
                                state_d = S_GAP;
                            end else if (reload_ok) begin
                                rem_d  = i_burst_len;
                                pcnt_d = '0;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (tick) begin
                        pcnt_d = pcnt_q + PERIOD_W'(1);
                        if (gap_done) begin
                            if (reload_ok) begin
                                state_d = S_BURST;
                                rem_d   = i_burst_len;
                                pcnt_d  = '0;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            dcnt_q      <= '0;
            trig_q      <= 1'b0;
            trig_prev_q <= 1'b0;
            rem_q       <= '0;
            pcnt_q      <= '0;
            per_run_q   <= 1'b0;
            valid_q     <= 1'b0;
            corrupt_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            trig_q      <= i_trigger;
            trig_prev_q <= trig_q;
            rem_q       <= rem_d;
            pcnt_q      <= pcnt_d;
            per_run_q   <= per_run_d;
            valid_q     <= tick;
            corrupt_q   <= corrupt_d;
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign o_valid   = valid_q;
    assign o_corrupt = corrupt_q;
    assign o_busy    = busy_q;

`ifdef ERR_INJ_BURST_CNT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        done;

    // Mirrors the completion branch of the BURST state above.
    assign done  = tick && (state_q == S_BURST) && (i_mode != M_CONT) && !abort &&
                   (rem_q <= BURST_W'(1));
    assign cnt_d = (done && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_burst_cnt = cnt_q;
`else
    assign o_burst_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_lfsr_err_injector.sv
// Bench for lfsr_err_injector: hand-computed vector table, corner-case sequences and a random run against a tick-level model.
module tb_lfsr_err_injector;

`ifdef ERR_INJ_BURST_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_enable = 1'b0;
    logic [7:0]  i_valid_div = 8'd0;
    logic [1:0]  i_mode = 2'd0;
    logic        i_trigger = 1'b0;
    logic [15:0] i_period = 16'd0;
    logic [7:0]  i_burst_len = 8'd0;
    logic        o_valid, o_corrupt, o_busy;
    logic [15:0] o_burst_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    lfsr_err_injector #(.PERIOD_W(16), .BURST_W(8)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_enable    (i_enable),
        .i_valid_div (i_valid_div),
        .i_mode      (i_mode),
        .i_trigger   (i_trigger),
        .i_period    (i_period),
        .i_burst_len (i_burst_len),
        .o_valid     (o_valid),
        .o_corrupt   (o_corrupt),
        .o_busy      (o_busy),
        .o_burst_cnt (o_burst_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: counts ticks since the enable, remembers how many corrupted
    // ticks are still owed in the current burst and how many ticks since it started.
    typedef struct {
        int dcnt;
        bit h1, h2;
        bit active, periodic;
        int left, since;
        bit valid, corrupt, busy;
        int cnt;
    } mdl_t;

    mdl_t m = '{default: 0};

    function automatic mdl_t start_burst(mdl_t s, int blen);
        mdl_t r = s;
        if (blen == 0) r.active = 0;
        else begin r.active = 1; r.left = blen; r.since = 0; end
        return r;
    endfunction

    function automatic mdl_t mdl_step(mdl_t s);
        mdl_t r = s;
        int  blen = int'(i_burst_len);
        int  per  = int'(i_period);
        bit  tk   = i_enable && (s.dcnt >= int'(i_valid_div));
        bit  rise = s.h1 && !s.h2;
        bit  corr = 0;
        r.dcnt = !i_enable ? 0 : (tk ? 0 : s.dcnt + 1);
        r.h2 = s.h1;
        r.h1 = i_trigger;
        if (i_mode == 2'd3) begin
            corr = tk;
            r.active = 0;
        end else if (s.active && (!i_enable || (i_mode != (s.periodic ? 2'd2 : 2'd1)))) begin
            r.active = 0;
        end else if (!s.active) begin
            if (i_enable && ((i_mode == 2'd1 && rise) || i_mode == 2'd2)) begin
                r = start_burst(r, blen);
                r.periodic = (i_mode == 2'd2);
            end
        end else if (tk) begin
            r.since = s.since + 1;
            if (s.left > 0) begin
                corr   = 1;
                r.left = s.left - 1;
                if (r.left == 0) begin
                    if (CNT_EN && s.cnt < 65535) r.cnt = s.cnt + 1;
                    if (!s.periodic) r.active = 0;
                    else if (per <= blen) r = start_burst(r, blen);
                end
            end else if (r.since >= per) begin
                r = start_burst(r, blen);
            end
        end
        r.valid   = tk;
        r.corrupt = corr;
        r.busy    = r.active;
        return r;
    endfunction

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) m <= '{default: 0};
        else       m <= mdl_step(m);
    end

    always @(negedge i_clk) begin
        check({o_valid, o_corrupt, o_busy, o_burst_cnt} ==
              {m.valid, m.corrupt, m.busy, 16'(m.cnt)}, "model_cycle",
              {o_valid, o_corrupt, o_busy, o_burst_cnt},
              {m.valid, m.corrupt, m.busy, 16'(m.cnt)});
        check(!(o_corrupt && !o_valid), "corrupt_without_valid", o_corrupt, o_valid);
    end

    typedef struct {
        logic [7:0] div;
        logic [1:0] mode;
        int         blen, per;
        bit         trig;
        int         ncyc, ev, ec, ecnt;
        bit         ebusy;
    } vec_t;

    task automatic do_reset();
        @(negedge i_clk);
        #2;
        i_rst = 1'b1; i_enable = 1'b0; i_trigger = 1'b0; i_mode = 2'd0;
        @(negedge i_clk);
        #2;
        i_rst = 1'b0;
    endtask

    task automatic start_run(input logic [7:0] div, input logic [1:0] mode,
                             input int blen, input int per, input bit trig);
        @(negedge i_clk);
        i_valid_div = div; i_mode = mode; i_burst_len = 8'(blen);
        i_period = 16'(per); i_trigger = trig; i_enable = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int nv = 0, nc = 0;
        do_reset();
        start_run(v.div, v.mode, v.blen, v.per, v.trig);
        for (int k = 1; k <= v.ncyc; k++) begin
            @(negedge i_clk);
            nv += int'(o_valid);
            nc += int'(o_corrupt);
            if (k == 1) i_trigger = 1'b0;
        end
        check(nv == v.ev, $sformatf("vec%0d_valid_count", idx), nv, v.ev);
        check(nc == v.ec, $sformatf("vec%0d_corrupt_count", idx), nc, v.ec);
        check(int'(o_burst_cnt) == (CNT_EN ? v.ecnt : 0), $sformatf("vec%0d_burst_cnt", idx),
              o_burst_cnt, CNT_EN ? v.ecnt : 0);
        check(o_busy == v.ebusy, $sformatf("vec%0d_busy", idx), o_busy, v.ebusy);
    endtask

    initial begin
        vec_t vecs[8];
        int   nc;

        vecs[0] = '{8'd3, 2'd0, 5, 8, 1'b0, 40, 10,  0, 0, 1'b0};  // off: strobe every 4 cycles
        vecs[1] = '{8'd0, 2'd1, 5, 8, 1'b1, 20, 20,  5, 1, 1'b0};  // single burst of 5
        vecs[2] = '{8'd1, 2'd2, 2, 8, 1'b0, 48, 24,  6, 3, 1'b1};  // 2 corrupted / 6 clean
        vecs[3] = '{8'd0, 2'd2, 4, 3, 1'b0, 20, 20, 19, 4, 1'b1};  // period <= burst: back-to-back
        vecs[4] = '{8'd0, 2'd2, 0, 3, 1'b0, 20, 20,  0, 0, 1'b0};  // zero burst length
        vecs[5] = '{8'd2, 2'd3, 5, 8, 1'b0, 30, 10, 10, 0, 1'b0};  // continuous
        vecs[6] = '{8'd0, 2'd2, 3, 0, 1'b0, 13, 13, 12, 4, 1'b1};  // period 0
        vecs[7] = '{8'd0, 2'd1, 5, 8, 1'b0, 10, 10,  0, 0, 1'b0};  // single, no trigger

        @(negedge i_clk);
        #2 i_rst = 1'b0;
        @(negedge i_clk);
        check({o_valid, o_corrupt, o_busy, o_burst_cnt} == 19'd0, "reset_state",
              {o_valid, o_corrupt, o_busy, o_burst_cnt}, 0);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Retrigger during a single burst is discarded; busy timing around the burst.
        do_reset();
        start_run(8'd0, 2'd1, 5, 8, 1'b1);
        nc = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge i_clk);
            nc += int'(o_corrupt);
            if (k == 1) i_trigger = 1'b0;
            if (k == 3) i_trigger = 1'b1;
            if (k == 4) i_trigger = 1'b0;
            if (k == 2) check(o_busy == 1'b1, "busy_after_detect", o_busy, 1);
            if (k == 3) check(o_corrupt == 1'b1, "first_corrupt_tick", o_corrupt, 1);
            if (k == 7) check({o_corrupt, o_busy} == 2'b10, "busy_falls_with_last", {o_corrupt, o_busy}, 2);
        end
        check(nc == 5, "retrigger_ignored_corrupts", nc, 5);
        check(int'(o_burst_cnt) == (CNT_EN ? 1 : 0), "retrigger_ignored_cnt", o_burst_cnt, CNT_EN ? 1 : 0);

        // Asynchronous reset in the middle of a burst of 10.
        do_reset();
        start_run(8'd0, 2'd1, 10, 8, 1'b1);
        nc = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge i_clk);
            nc += int'(o_corrupt);
            if (k == 1) i_trigger = 1'b0;
        end
        check(nc == 4, "pre_reset_corrupts", nc, 4);
        #2 i_rst = 1'b1;
        #1;
        check({o_valid, o_corrupt, o_busy, o_burst_cnt} == 19'd0, "async_reset_clear",
              {o_valid, o_corrupt, o_busy, o_burst_cnt}, 0);
        @(negedge i_clk);
        #2 i_rst = 1'b0;
        nc = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge i_clk);
            nc += int'(o_corrupt);
        end
        check(nc == 0, "post_reset_corrupts", nc, 0);
        check(o_burst_cnt == 16'd0, "post_reset_cnt", o_burst_cnt, 0);

        // Mode switch to off in the middle of a burst of 10.
        do_reset();
        start_run(8'd0, 2'd1, 10, 8, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge i_clk);
            if (k == 1) i_trigger = 1'b0;
        end
        i_mode = 2'd0;
        @(negedge i_clk);
        check({o_corrupt, o_busy} == 2'b00, "abort_next_edge", {o_corrupt, o_busy}, 0);
        nc = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge i_clk);
            nc += int'(o_corrupt);
        end
        check(nc == 0, "abort_no_corrupts", nc, 0);
        check(o_burst_cnt == 16'd0, "abort_cnt_unchanged", o_burst_cnt, 0);

        // Random run; every cycle is compared to the model by the negedge checker.
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            @(negedge i_clk);
            if ($urandom_range(0, 99) == 0) begin
                i_valid_div = 8'($urandom_range(0, 3));
                i_mode      = 2'($urandom_range(0, 3));
                i_burst_len = 8'($urandom_range(0, 5));
                i_period    = 16'($urandom_range(0, 10));
            end
            if ($urandom_range(0, 199) == 0) i_burst_len = 8'($urandom_range(0, 5));
            i_trigger = ($urandom_range(0, 7) == 0);
            i_enable  = ($urandom_range(0, 49) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
